// File: rtl/axis_pkt_tx.sv
// axis_pkt_tx: sample buffer that feeds fixed-length AXI-Stream packets
// carrying a rolling packet ID, a per-packet destination and an idle gap after each packet.
module axis_pkt_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_LEN    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_full,
    output logic                        wr_ovf,
    input  logic [3:0]                  cfg_tdest,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_tlast,
    output logic [7:0]                  m_tid,
    output logic [3:0]                  m_tdest,
    output logic [DATA_WIDTH/8-1:0]     m_tkeep,
    output logic [DATA_WIDTH/8-1:0]     m_tstrb
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LAST = 8'(PKT_LEN - 1);
    localparam logic [3:0] GAP_END = 4'(GAP_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr, r_rptr;
    logic [AW:0]           r_cnt;
    logic [7:0]            r_beat, w_beat;
    logic [3:0]            r_gap;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid, r_tlast;
    logic [7:0]            r_tid;
    logic [3:0]            r_tdest;
    logic                  w_wr, w_hs, w_close, w_pop, w_avail;
    // the word on the bus still counts toward level until it is handshaken
    assign level         = r_cnt + (AW+1)'(r_tvalid);
    assign wr_full       = level == (AW+1)'(FIFO_DEPTH);
    assign wr_ovf        = wr_en & wr_full;
    assign w_wr          = wr_en & ~wr_full & ~rst;
    assign w_avail       = r_cnt != '0;
    assign w_hs          = r_tvalid & m_axis_tready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_tlast       = r_tlast;
    assign m_tid         = r_tid;
    assign m_tdest       = r_tdest;
    assign m_tkeep       = '1;
    assign m_tstrb       = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_gap    <= '0;
            r_beat   <= '0;
            r_tid    <= '0;
            r_tdest  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            r_wptr  <= r_wptr + AW'(w_wr);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_gap   <= r_state == GAP ? r_gap + 4'd1 : 4'd0;
            r_beat  <= w_close ? 8'd0 : w_beat;
            r_tid   <= r_tid + 8'(w_close);
            if (w_pop) begin
                r_tdata  <= r_mem[r_rptr];
                r_tvalid <= 1'b1;
                r_tlast  <= w_beat == LAST;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            if (r_state == IDLE && w_avail) r_tdest <= cfg_tdest;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wr_data;
    end

    always_comb begin
        w_next = r_state == IDLE ? (w_avail ? SEND : IDLE)
               : r_state == SEND ? (w_close ? (GAP_CYCLES > 0 ? GAP : IDLE) : SEND)
               : (r_gap == GAP_END ? IDLE : GAP);
    end

    // a stalled-empty SEND refills as soon as data arrives, keeping the beat count
    always_comb begin
        w_close = r_state == SEND && w_hs && r_tlast;
        w_beat  = (r_state == SEND && w_hs && !r_tlast) ? r_beat + 8'd1 : r_beat;
        w_pop   = w_avail && (r_state == IDLE || (r_state == SEND && !w_close && (w_hs || !r_tvalid)));
    end
endmodule

// File: tb/tb_axis_pkt_tx.sv
// tb_axis_pkt_tx: directed and randomized checks of axis_pkt_tx against a
// queue-based model of words in flight, packet numbering and bus timing.
module tb_axis_pkt_tx;
    localparam int DW = 16, FD = 16, PL = 8, GC = 2;
    logic clk = 0, rst = 0, wr_en = 0, m_axis_tready = 0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0] cfg_tdest = '0;
    logic wr_full, wr_ovf, m_axis_tvalid, m_tlast;
    logic [$clog2(FD):0] level;
    logic [DW-1:0] m_axis_tdata;
    logic [7:0] m_tid;
    logic [3:0] m_tdest;
    logic [DW/8-1:0] m_tkeep, m_tstrb;

    axis_pkt_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .PKT_LEN(PL), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .wr_ovf(wr_ovf), .cfg_tdest(cfg_tdest), .level(level), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest), .m_tkeep(m_tkeep), .m_tstrb(m_tstrb));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] q[$];
    int hs_cyc[$];
    int n_lvl = 0, beat = 0, tid_m = 0, edge_n = 0, ovf_seen = 0, pkts = 0, last_tid = -1, n_acc = 0;
    logic [3:0] exp_dest = '0, dest_next = '0;
    logic stalled = 0, p_last = 0;
    logic [DW-1:0] p_data = '0;
    logic [7:0] p_tid = '0;
    logic [3:0] p_dest = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock of the model: words in flight, packet position, stall stability
    task automatic cyc();
        logic full_m, hs;
        logic [DW-1:0] d;
        @(negedge clk);
        full_m = n_lvl == FD;
        chk("wr_full", 32'(wr_full), 32'(full_m));
        chk("wr_ovf", 32'(wr_ovf), 32'(wr_en && full_m));
        if (wr_ovf) ovf_seen++;
        if (stalled) begin
            chk("stall_tvalid", 32'(m_axis_tvalid), 32'(1));
            chk("stall_tdata", 32'(m_axis_tdata), 32'(p_data));
            chk("stall_tlast", 32'(m_tlast), 32'(p_last));
            chk("stall_tid", 32'(m_tid), 32'(p_tid));
            chk("stall_tdest", 32'(m_tdest), 32'(p_dest));
        end
        hs = m_axis_tvalid && m_axis_tready;
        if (hs && q.size() == 0) chk("beat_when_empty", 32'(hs), 32'(0));
        else if (hs) begin
            d = q.pop_front();
            chk("tdata", 32'(m_axis_tdata), 32'(d));
            chk("tlast", 32'(m_tlast), 32'(beat == PL - 1));
            chk("tid", 32'(m_tid), 32'(tid_m % 256));
            chk("tdest", 32'(m_tdest), 32'(exp_dest));
            hs_cyc.push_back(edge_n + 1);
            n_lvl--;
            if (beat == PL - 1) begin
                beat = 0;
                tid_m++;
                pkts++;
                last_tid = int'(m_tid);
                exp_dest = dest_next;
            end else beat++;
        end
        if (wr_en && !full_m) begin
            q.push_back(wr_data);
            n_lvl++;
            n_acc++;
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        p_data = m_axis_tdata;
        p_last = m_tlast;
        p_tid = m_tid;
        p_dest = m_tdest;
        @(posedge clk);
        edge_n++;
        #1;
        chk("level", 32'(level), 32'(n_lvl));
    endtask

    task automatic do_reset(input logic wr_during);
        wr_en = wr_during;
        wr_data = 16'hDEAD;
        rst = 1;
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rst_tdata", 32'(m_axis_tdata), 32'(0));
        chk("rst_tlast", 32'(m_tlast), 32'(0));
        chk("rst_tid", 32'(m_tid), 32'(0));
        chk("rst_tdest", 32'(m_tdest), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_full", 32'(wr_full), 32'(0));
        chk("rst_ovf", 32'(wr_ovf), 32'(0));
        q.delete();
        n_lvl = 0;
        beat = 0;
        tid_m = 0;
        stalled = 0;
        exp_dest = cfg_tdest;
        dest_next = cfg_tdest;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_ignored", 32'(level), 32'(0));
        rst = 0;
        wr_en = 0;
    endtask

    task automatic drain(input int budget, input logic tog);
        int i = 0;
        while (n_lvl > 0 && i < budget) begin
            if (tog) m_axis_tready = ~m_axis_tready;
            cyc();
            i++;
        end
        chk("drain_timeout", 32'(n_lvl), 32'(0));
        m_axis_tready = 1;
    endtask

    initial begin
        int first_edge;
        #2;
        do_reset(1'b0);
        chk("tkeep", 32'(m_tkeep), 32'(2'b11));
        chk("tstrb", 32'(m_tstrb), 32'(2'b11));

        // two back-to-back packets with tready high: latency, throughput, gap, tid
        m_axis_tready = 1;
        hs_cyc.delete();
        first_edge = edge_n + 1;
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1;
            wr_data = DW'(i);
            cyc();
        end
        wr_en = 0;
        drain(100, 1'b0);
        chk("beats_2pkt", 32'(hs_cyc.size()), 32'(16));
        chk("latency", 32'(hs_cyc[0]), 32'(first_edge + 2));
        for (int i = 1; i < PL; i++) chk("throughput", 32'(hs_cyc[i]), 32'(hs_cyc[0] + i));
        chk("gap", 32'(hs_cyc[PL]), 32'(hs_cyc[PL-1] + GC + 2));
        chk("tid_after_2pkt", 32'(m_tid), 32'(2));

        // overflow: 24 writes while stalled, writes also attempted during reset
        do_reset(1'b1);
        m_axis_tready = 0;
        ovf_seen = 0;
        for (int i = 0; i < 24; i++) begin
            wr_en = 1;
            wr_data = DW'($urandom);
            cyc();
        end
        wr_en = 0;
        chk("full_level", 32'(level), 32'(FD));
        chk("full_flag", 32'(wr_full), 32'(1));
        chk("ovf_count", 32'(ovf_seen), 32'(8));
        pkts = 0;
        m_axis_tready = 1;
        drain(100, 1'b0);
        chk("pkts_after_ovf", 32'(pkts), 32'(2));

        // random writes with tready toggling every cycle
        for (int i = 0; i < 80; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_data = DW'($urandom);
            m_axis_tready = ~m_axis_tready;
            cyc();
        end
        wr_en = 0;
        drain(200, 1'b1);

        // reset after the third beat of a packet
        do_reset(1'b0);
        hs_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1;
            wr_data = DW'($urandom);
            cyc();
        end
        chk("beats_before_rst", 32'(hs_cyc.size()), 32'(3));
        do_reset(1'b0);
        pkts = 0;
        for (int i = 0; i < PL; i++) begin
            wr_en = 1;
            wr_data = DW'($urandom);
            cyc();
        end
        wr_en = 0;
        drain(100, 1'b0);
        chk("pkts_after_rst", 32'(pkts), 32'(1));
        chk("tid_after_rst", 32'(m_tid), 32'(1));

        // destination change mid-packet only affects the next packet
        cfg_tdest = 4'h3;
        do_reset(1'b0);
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1;
            wr_data = DW'($urandom);
            if (i == 6) begin
                cfg_tdest = 4'hA;
                dest_next = 4'hA;
            end
            cyc();
        end
        wr_en = 0;
        drain(100, 1'b0);
        chk("tdest_final", 32'(m_tdest), 32'(4'hA));

        // 257 packets: tid wraps 255 -> 0
        do_reset(1'b0);
        hs_cyc.delete();
        pkts = 0;
        n_acc = 0;
        for (int g = 0; n_acc < 257 * PL && g < 6000; g++) begin
            wr_en = 1;
            wr_data = DW'($urandom);
            cyc();
        end
        wr_en = 0;
        drain(100, 1'b0);
        chk("pkt_count", 32'(pkts), 32'(257));
        chk("last_tid", 32'(last_tid), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
